// File: rtl/gearbox_param.sv
// Parametrised IN_WORDS:OUT_WORDS word gearbox with per-word error tags,
// valid/ready on both sides, zero-padded flush of a partial tail and sticky overflow.
module gearbox_param #(
    parameter  int WORDSIZE    = 16,
    parameter  int IN_WORDS    = 4,
    parameter  int OUT_WORDS   = 3,
    parameter  int DEPTH_WORDS = 40,
    localparam int CNTW        = $clog2(DEPTH_WORDS + 1),
    localparam int PADW        = $clog2(OUT_WORDS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_WORDS*WORDSIZE-1:0]  in_data,
    input  logic                          in_valid,
    input  logic                          in_error,
    output logic                          in_ready,
    input  logic                          in_flush,
    output logic [OUT_WORDS*WORDSIZE-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_error,
    output logic [PADW-1:0]               out_pad_words,
    output logic [CNTW-1:0]               level,
    output logic                          overflow
);

    localparam int PTRW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    generate
        if (DEPTH_WORDS < IN_WORDS + OUT_WORDS) begin : g_bad_depth
            $error("gearbox_param: DEPTH_WORDS must be >= IN_WORDS + OUT_WORDS");
        end
    endgenerate

    // Circular index: base + off modulo DEPTH_WORDS, valid for off <= DEPTH_WORDS.
    function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] base,
                                                 input int unsigned     off);
        logic [PTRW:0] sum;
        sum = {1'b0, base} + (PTRW+1)'(off);
        if (sum >= (PTRW+1)'(DEPTH_WORDS))
            sum = sum - (PTRW+1)'(DEPTH_WORDS);
        return sum[PTRW-1:0];
    endfunction

    logic [WORDSIZE-1:0]    r_mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] r_tag;
    logic [PTRW-1:0]        r_rd_ptr;
    logic [PTRW-1:0]        r_wr_ptr;
    logic [CNTW-1:0]        r_level;
    logic                   r_overflow;
    state_t                 r_state;

    state_t                 w_state_next;
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic [PADW-1:0]        w_pad;
    logic [CNTW-1:0]        w_real;
    logic [CNTW-1:0]        w_level_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_err;
    logic [PTRW-1:0]        w_rd_idx [OUT_WORDS];
    logic [PTRW-1:0]        w_wr_idx [IN_WORDS];

    for (genvar k = 0; k < OUT_WORDS; k++) begin : g_rd_idx
        assign w_rd_idx[k] = wrap_add(r_rd_ptr, k);
    end
    for (genvar k = 0; k < IN_WORDS; k++) begin : g_wr_idx
        assign w_wr_idx[k] = wrap_add(r_wr_ptr, k);
    end

    assign w_real = (r_level >= CNTW'(OUT_WORDS)) ? CNTW'(OUT_WORDS) : r_level;
    assign w_push = in_valid & w_in_ready;
    assign w_pop  = w_out_valid & out_ready;

    always_comb begin
        w_level_next = r_level;
        if (w_push)
            w_level_next = w_level_next + CNTW'(IN_WORDS);
        if (w_pop)
            w_level_next = w_level_next - w_real;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    // A push in the flush cycle is counted before deciding whether there is a tail to drain.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (in_flush && w_level_next != '0) w_state_next = ST_FLUSH;
            ST_FLUSH: if (w_pop && w_level_next == '0) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_pad       = '0;
        case (r_state)
            ST_RUN: begin
                w_in_ready  = (CNTW'(DEPTH_WORDS) - r_level) >= CNTW'(IN_WORDS);
                w_out_valid = r_level >= CNTW'(OUT_WORDS);
            end
            ST_FLUSH: begin
                w_out_valid = r_level != '0;
                w_pad       = PADW'(OUT_WORDS) - PADW'(w_real);
            end
            default: ;
        endcase
    end

    always_comb begin
        out_data = '0;
        w_err    = 1'b0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            if (w_out_valid && CNTW'(k) < w_real) begin
                out_data[k*WORDSIZE +: WORDSIZE] = r_mem[w_rd_idx[k]];
                w_err = w_err | r_tag[w_rd_idx[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_level <= w_level_next;
            if (w_push) begin
                r_wr_ptr <= wrap_add(r_wr_ptr, IN_WORDS);
                for (int k = 0; k < IN_WORDS; k++)
                    r_tag[w_wr_idx[k]] <= in_error;
            end
            if (w_pop)
                r_rd_ptr <= wrap_add(r_rd_ptr, 32'(w_real));
            if (in_valid && !w_in_ready)
                r_overflow <= 1'b1;
        end
    end

    // NOTE: the word storage has no reset; level masks stale entries from the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < IN_WORDS; k++)
                r_mem[w_wr_idx[k]] <= in_data[k*WORDSIZE +: WORDSIZE];
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign out_error     = w_err;
    assign out_pad_words = w_pad;
    assign level         = r_level;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_gearbox_param.sv
// Directed bench for gearbox_param (16/4/3/40): expected output beats are queued
// at stimulus time and compared by an independent monitor on every handshake.
module tb_gearbox_param;

    typedef struct {
        logic [47:0] data;
        logic        err;
        logic [1:0]  pad;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_error = 1'b0;
    logic        in_ready;
    logic        in_flush = 1'b0;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_error;
    logic [1:0]  out_pad_words;
    logic [5:0]  level;
    logic        overflow;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    gearbox_param dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_error      (in_error),
        .in_ready      (in_ready),
        .in_flush      (in_flush),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_error     (out_error),
        .out_pad_words (out_pad_words),
        .level         (level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ib(input int base);
        return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
    endfunction

    function automatic exp_t ob(input int w0, input int w1, input int w2,
                                input logic err, input logic [1:0] pad);
        exp_t e;
        e.data = {16'(w2), 16'(w1), 16'(w0)};
        e.err  = err;
        e.pad  = pad;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        sb.delete();
        cyc();
        reset = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input logic err);
        in_data  = d;
        in_error = err;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic pulse_flush();
        in_flush = 1'b1;
        cyc();
        in_flush = 1'b0;
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h required no beat", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_error", 64'(out_error), 64'(e.err));
                check("out_pad_words", 64'(out_pad_words), 64'(e.pad));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_level;
        int ecnt;
        int wcnt;

        // Reset state, then two beats without popping
        do_reset();
        check("rst_level", 64'(level), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_out_error", 64'(out_error), 0);
        check("rst_pad", 64'(out_pad_words), 0);
        check("rst_overflow", 64'(overflow), 0);
        push(ib(1), 1'b0);
        check("t1_latency_valid", 64'(out_valid), 1);
        push(ib(5), 1'b0);
        check("t1_level", 64'(level), 8);
        check("t1_out_data", 64'(out_data), 64'h0003_0002_0001);
        check("t1_out_valid", 64'(out_valid), 1);
        sb.push_back(ob(1, 2, 3, 1'b0, 2'd0));
        sb.push_back(ob(4, 5, 6, 1'b0, 2'd0));
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        check("t1_level_after_pop", 64'(level), 2);
        check("t1_run_partial_valid", 64'(out_valid), 0);
        sb.push_back(ob(7, 8, 0, 1'b0, 2'd1));
        pulse_flush();
        check("t1_flush_valid", 64'(out_valid), 1);
        check("t1_flush_in_ready", 64'(in_ready), 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t1_drained_level", 64'(level), 0);
        check("t1_drained_in_ready", 64'(in_ready), 1);

        // Continuous push and pop for 30 beats
        do_reset();
        out_ready = 1'b1;
        exp_level = 0;
        ecnt = 0;
        wcnt = 0;
        for (int b = 0; b < 30; b++) begin
            check("t2_level", 64'(level), 64'(exp_level));
            check("t2_in_ready", 64'(in_ready), 64'(exp_level <= 36));
            in_data  = ib(4 * b + 1);
            in_valid = 1'b1;
            wcnt += 4;
            while (wcnt - ecnt >= 3) begin
                sb.push_back(ob(ecnt + 1, ecnt + 2, ecnt + 3, 1'b0, 2'd0));
                ecnt += 3;
            end
            exp_level = exp_level + 4 - ((exp_level >= 3) ? 3 : 0);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 60 && exp_level >= 3; i++) begin
            exp_level -= 3;
            cyc();
        end
        out_ready = 1'b0;
        check("t2_final_level", 64'(level), 0);
        check("t2_overflow", 64'(overflow), 0);
        check("t2_sb_drained", 64'(sb.size()), 0);

        // Fill to capacity, then drop a beat
        do_reset();
        for (int b = 0; b < 10; b++) begin
            check("t3_in_ready_fill", 64'(in_ready), 1);
            push(ib(4 * b + 1), 1'b0);
        end
        check("t3_full_level", 64'(level), 40);
        check("t3_full_in_ready", 64'(in_ready), 0);
        check("t3_no_overflow_yet", 64'(overflow), 0);
        push(ib(41), 1'b0);
        check("t3_overflow", 64'(overflow), 1);
        check("t3_level_after_drop", 64'(level), 40);
        cyc();
        cyc();
        check("t3_overflow_held", 64'(overflow), 1);
        sb.push_back(ob(1, 2, 3, 1'b0, 2'd0));
        sb.push_back(ob(4, 5, 6, 1'b0, 2'd0));
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        check("t3_level_after_pop", 64'(level), 34);
        check("t3_in_ready_after_pop", 64'(in_ready), 1);
        check("t3_overflow_sticky", 64'(overflow), 1);

        // Single-word flush tail
        do_reset();
        push(ib(1), 1'b0);
        sb.push_back(ob(1, 2, 3, 1'b0, 2'd0));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        sb.push_back(ob(4, 0, 0, 1'b0, 2'd2));
        pulse_flush();
        check("t4_tail_data", 64'(out_data), 64'h0000_0000_0004);
        check("t4_tail_pad", 64'(out_pad_words), 2);
        check("t4_tail_in_ready", 64'(in_ready), 0);
        cyc();
        check("t4_hold_data", 64'(out_data), 64'h0000_0000_0004);
        check("t4_hold_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("t4_level", 64'(level), 0);
        check("t4_in_ready", 64'(in_ready), 1);
        check("t4_pad_run", 64'(out_pad_words), 0);

        // Error tags stay aligned with their words
        do_reset();
        push(ib(1), 1'b0);
        push(ib(5), 1'b1);
        sb.push_back(ob(1, 2, 3, 1'b0, 2'd0));
        sb.push_back(ob(4, 5, 6, 1'b1, 2'd0));
        sb.push_back(ob(7, 8, 0, 1'b1, 2'd1));
        out_ready = 1'b1;
        cyc();
        cyc();
        pulse_flush();
        for (int i = 0; i < 10 && level != 0; i++)
            cyc();
        out_ready = 1'b0;
        check("t5_level", 64'(level), 0);
        check("t5_in_ready", 64'(in_ready), 1);

        // Reset mid-operation with data buffered and overflow set
        do_reset();
        for (int b = 0; b < 5; b++)
            push(ib(4 * b + 1), 1'b0);
        pulse_flush();
        push(ib(21), 1'b0);
        check("t6_pre_level", 64'(level), 20);
        check("t6_pre_overflow", 64'(overflow), 1);
        do_reset();
        check("t6_level", 64'(level), 0);
        check("t6_out_valid", 64'(out_valid), 0);
        check("t6_overflow", 64'(overflow), 0);
        check("t6_in_ready", 64'(in_ready), 1);
        check("t6_pad", 64'(out_pad_words), 0);

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
